// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared definitions for the traffic sensor conditioner: the debounce state
// encoding and the default parameter values used by the top level and the
// per-road debounce sub-module. No ports.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // debounced level 0
    ST_RISE_CHK = 2'd1,  // candidate 1, counting stable samples
    ST_PRESENT  = 2'd2,  // debounced level 1
    ST_FALL_CHK = 2'd3   // candidate 0, counting stable samples
  } deb_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_DEPART_CYCLES   = 3;
  localparam int DEF_CNT_W           = 4;

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce
// One road's loop-detector front end: a 2-flop synchronizer followed by a
// four-state debounce FSM. Emits a one-cycle arrival pulse when a rising level
// has been stable for DEBOUNCE_CYCLES synchronized samples.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   raw_in   in   asynchronous loop-detector level
//   arrival  out  one-cycle pulse, high in the cycle the FSM enters PRESENT
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic arrival
);

  // Counter value on the sample that completes DEBOUNCE_CYCLES stable samples.
  localparam logic [3:0] STAB_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q;
  logic       sync2_q;
  deb_state_e state_q, state_d;
  logic [3:0] stab_q, stab_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_IDLE;
      stab_q  <= 4'd0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      stab_q  <= stab_d;
    end
  end

  // The arrival pulse is decoded from the completing sample itself so the
  // queue counter updates on the same edge the FSM enters PRESENT.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    arrival = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          state_d = ST_RISE_CHK;
          stab_d  = 4'd1;
        end
      end
      ST_RISE_CHK: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
          stab_d  = 4'd0;
        end else if (stab_q == STAB_LAST) begin
          state_d = ST_PRESENT;
          stab_d  = 4'd0;
          arrival = 1'b1;
        end else begin
          stab_d = stab_q + 4'd1;
        end
      end
      ST_PRESENT: begin
        if (!sync2_q) begin
          state_d = ST_FALL_CHK;
          stab_d  = 4'd1;
        end
      end
      ST_FALL_CHK: begin
        if (sync2_q) begin
          state_d = ST_PRESENT;
          stab_d  = 4'd0;
        end else if (stab_q == STAB_LAST) begin
          state_d = ST_IDLE;
          stab_d  = 4'd0;
        end else begin
          stab_d = stab_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        stab_d  = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner
// Conditions the highway and country loop detectors into per-road vehicle
// queues and service requests for the light controller.
// Ports:
//   clk, reset                      clock and asynchronous active-high reset
//   raw_highway, raw_country        asynchronous loop-detector levels
//   Greenhigh, Greencountry         green lamp feedback from the controller
//   highway_road, country_road      registered service requests (count != 0)
//   highway_count, country_count    queued vehicles, saturating at 2^CNT_W-1
//   highway_ovf, country_ovf        sticky: arrival seen while saturated
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DEPART_CYCLES   = DEF_DEPART_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_highway,
  input  logic             raw_country,
  input  logic             Greenhigh,
  input  logic             Greencountry,
  output logic             highway_road,
  output logic             country_road,
  output logic [CNT_W-1:0] highway_count,
  output logic [CNT_W-1:0] country_count,
  output logic             highway_ovf,
  output logic             country_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       TMR_LAST = 4'(DEPART_CYCLES - 1);

  // Index 0 is the highway, index 1 the country road.
  logic [1:0]       arrival;
  logic [1:0]       green;
  logic [1:0]       depart;
  logic [CNT_W-1:0] count_q [2];
  logic [CNT_W-1:0] count_d [2];
  logic [3:0]       tmr_q   [2];
  logic [3:0]       tmr_d   [2];
  logic [1:0]       ovf_q, ovf_d;
  logic [1:0]       road_q, road_d;

  assign green = {Greencountry, Greenhigh};

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_highway (
    .clk     (clk),
    .rst     (reset),
    .raw_in  (raw_highway),
    .arrival (arrival[0])
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_country (
    .clk     (clk),
    .rst     (reset),
    .raw_in  (raw_country),
    .arrival (arrival[1])
  );

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      tmr_d[r]   = 4'd0;
      depart[r]  = 1'b0;
      count_d[r] = count_q[r];
      ovf_d[r]   = ovf_q[r];
      road_d[r]  = (count_q[r] != '0);
      // Timer only runs while this road is being served and has vehicles;
      // each road is independent even if both greens are lit.
      if (green[r] && (count_q[r] != '0)) begin
        if (tmr_q[r] == TMR_LAST) begin
          depart[r] = 1'b1;
        end else begin
          tmr_d[r] = tmr_q[r] + 4'd1;
        end
      end
      // Coincident arrival and departure cancel, so saturation cannot flag.
      // A departure implies a nonzero count, so the decrement cannot wrap.
      case ({arrival[r], depart[r]})
        2'b10: begin
          if (count_q[r] == CNT_MAX) begin
            ovf_d[r] = 1'b1;
          end else begin
            count_d[r] = count_q[r] + CNT_ONE;
          end
        end
        2'b01:   count_d[r] = count_q[r] - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 2; r++) begin
        count_q[r] <= '0;
        tmr_q[r]   <= 4'd0;
      end
      ovf_q  <= 2'b00;
      road_q <= 2'b00;
    end else begin
      for (int r = 0; r < 2; r++) begin
        count_q[r] <= count_d[r];
        tmr_q[r]   <= tmr_d[r];
      end
      ovf_q  <= ovf_d;
      road_q <= road_d;
    end
  end

  assign highway_count = count_q[0];
  assign country_count = count_q[1];
  assign highway_ovf   = ovf_q[0];
  assign country_ovf   = ovf_q[1];
  assign highway_road  = road_q[0];
  assign country_road  = road_q[1];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed testbench for traffic_sensor_conditioner with default parameters
// (DEBOUNCE_CYCLES=4, DEPART_CYCLES=3, CNT_W=4).
module tb_traffic_sensor_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       raw_highway = 1'b0;
  logic       raw_country = 1'b0;
  logic       Greenhigh = 1'b0;
  logic       Greencountry = 1'b0;
  logic       highway_road;
  logic       country_road;
  logic [3:0] highway_count;
  logic [3:0] country_count;
  logic       highway_ovf;
  logic       country_ovf;

  int n_checks = 0;
  int n_errors = 0;

  traffic_sensor_conditioner dut (
    .clk           (clk),
    .reset         (reset),
    .raw_highway   (raw_highway),
    .raw_country   (raw_country),
    .Greenhigh     (Greenhigh),
    .Greencountry  (Greencountry),
    .highway_road  (highway_road),
    .country_road  (country_road),
    .highway_count (highway_count),
    .country_count (country_count),
    .highway_ovf   (highway_ovf),
    .country_ovf   (country_ovf)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs change and outputs are
  // sampled there.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One complete vehicle: level high long enough to be accepted, then low
  // long enough for the FSM to return to IDLE.
  task automatic arrive(input logic country);
    if (country) raw_country = 1'b1; else raw_highway = 1'b1;
    tick(8);
    if (country) raw_country = 1'b0; else raw_highway = 1'b0;
    tick(8);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hw_road"}, 32'(highway_road), 0);
    check({tag, "_ct_road"}, 32'(country_road), 0);
    check({tag, "_hw_cnt"},  32'(highway_count), 0);
    check({tag, "_ct_cnt"},  32'(country_count), 0);
    check({tag, "_hw_ovf"},  32'(highway_ovf), 0);
    check({tag, "_ct_ovf"},  32'(country_ovf), 0);
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b1;
    tick(2);
    check_all_zero("reset");
    reset = 1'b0;
    tick(2);

    // Two-cycle glitch must not count
    raw_country = 1'b1;
    tick(2);
    raw_country = 1'b0;
    tick(10);
    check("glitch_road", 32'(country_road), 0);
    check("glitch_cnt",  32'(country_count), 0);

    // Arrival latency: request rises on the 7th edge after the level appears
    raw_country = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      if (i == 6) check("lat_road_e6", 32'(country_road), 0);
      if (i == 7) begin
        check("lat_road_e7", 32'(country_road), 1);
        check("lat_cnt_e7",  32'(country_count), 1);
      end
    end
    tick(13);
    check("dwell_cnt", 32'(country_count), 1);
    raw_country = 1'b0;
    tick(10);
    check("after_fall_cnt", 32'(country_count), 1);

    // Departures: 3 -> 2 -> 1 -> 0 every 3 cycles
    arrive(1'b1);
    arrive(1'b1);
    check("pre_dep_cnt", 32'(country_count), 3);
    Greencountry = 1'b1;
    tick(2);
    check("dep_cnt_t2", 32'(country_count), 3);
    tick(1);
    check("dep_cnt_t3", 32'(country_count), 2);
    tick(3);
    check("dep_cnt_t6", 32'(country_count), 1);
    tick(3);
    check("dep_cnt_t9",  32'(country_count), 0);
    check("dep_road_t9", 32'(country_road), 1);
    tick(1);
    check("dep_road_t10", 32'(country_road), 0);
    tick(3);
    check("dep_cnt_floor", 32'(country_count), 0);
    Greencountry = 1'b0;

    // Saturation on the highway
    for (int i = 0; i < 15; i++) arrive(1'b0);
    check("sat_cnt_15", 32'(highway_count), 15);
    check("sat_ovf_15", 32'(highway_ovf), 0);
    arrive(1'b0);
    check("sat_cnt_16", 32'(highway_count), 15);
    check("sat_ovf_16", 32'(highway_ovf), 1);
    tick(5);
    check("sat_ovf_sticky", 32'(highway_ovf), 1);
    check("sat_road", 32'(highway_road), 1);

    // Arrival coincident with a departure at count 2
    arrive(1'b1);
    arrive(1'b1);
    check("sim_pre_cnt", 32'(country_count), 2);
    raw_country = 1'b1;
    tick(3);
    Greencountry = 1'b1;
    tick(2);
    check("sim_cnt_e5", 32'(country_count), 2);
    tick(1);
    check("sim_cnt_e6", 32'(country_count), 2);
    check("sim_ovf_e6", 32'(country_ovf), 0);
    Greencountry = 1'b0;
    tick(3);
    check("sim_cnt_after", 32'(country_count), 2);
    raw_country = 1'b0;
    tick(8);

    // Reset in the middle of RISE_CHK with count 5
    arrive(1'b1);
    arrive(1'b1);
    arrive(1'b1);
    check("rst_pre_cnt", 32'(country_count), 5);
    raw_country = 1'b1;
    tick(4);
    reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    tick(2);
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      if (i == 6) check("rst_road_e6", 32'(country_road), 0);
      if (i == 7) begin
        check("rst_road_e7", 32'(country_road), 1);
        check("rst_cnt_e7",  32'(country_count), 1);
      end
    end
    check("rst_hw_cnt", 32'(highway_count), 0);
    raw_country = 1'b0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
